// File: rtl/freq_scheduler.sv
// Frequency-change sequencer: holds up to two keyboard notes and issues rate-limited id updates to physics.
// Optional build macro FREQ_SCHED_SORT_EN: present both valid ids in ascending order.
module freq_scheduler #(
    parameter int HOLDOFF_FRAMES = 4,
    parameter int MAX_ID         = 24,
    parameter int NONE_ID        = 31
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_vsync,
    input  logic       i_key_valid,
    input  logic       i_key_press,
    input  logic [4:0] i_key_id,
    input  logic       i_restart,
    output logic [4:0] o_freq_id1,
    output logic [4:0] o_freq_id2,
    output logic       o_new_f_in,
    output logic       o_r_offset,
    output logic       o_busy
);

    localparam logic [4:0] NONE = 5'(NONE_ID);
    localparam logic [4:0] MAXV = 5'(MAX_ID);
    localparam logic [3:0] HOLD = 4'(HOLDOFF_FRAMES);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_slot1;
    logic [4:0] r_slot2;
    logic [4:0] w_slot1_next;
    logic [4:0] w_slot2_next;
    logic       w_key_set;
    logic       r_dirty;
    logic       r_vsync_d;
    logic       w_fe;
    logic [3:0] r_cnt;
    logic       r_pend;
    logic       r_offset_q;
    logic       r_new_f_in;
    logic [4:0] r_freq_id1;
    logic [4:0] r_freq_id2;
    logic [4:0] w_out1;
    logic [4:0] w_out2;

    assign w_fe = r_vsync_d & ~i_vsync;

    // Restart wipes the held notes and swallows any key event in the same cycle.
    always_comb begin
        w_slot1_next = r_slot1;
        w_slot2_next = r_slot2;
        w_key_set    = 1'b0;
        if (i_restart) begin
            w_slot1_next = NONE;
            w_slot2_next = NONE;
        end else if (i_key_valid) begin
            if (i_key_press) begin
                if (i_key_id <= MAXV && i_key_id != r_slot1 && i_key_id != r_slot2) begin
                    w_key_set = 1'b1;
                    if (r_slot1 == NONE) w_slot1_next = i_key_id;
                    else                 w_slot2_next = i_key_id;
                end
            end else if (r_slot1 != NONE && i_key_id == r_slot1) begin
                w_slot1_next = r_slot2;
                w_slot2_next = NONE;
                w_key_set    = 1'b1;
            end else if (r_slot2 != NONE && i_key_id == r_slot2) begin
                w_slot2_next = NONE;
                w_key_set    = 1'b1;
            end
        end
    end

    // A key landing while idle is issued straight away so the pulse follows two cycles later.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (r_dirty || w_key_set) w_state_next = ISSUE;
            ISSUE:   w_state_next = HOLDOFF;
            HOLDOFF: if (r_cnt >= HOLD) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (i_restart) w_state_next = ISSUE;
    end

`ifdef FREQ_SCHED_SORT_EN
    always_comb begin
        w_out1 = r_slot1;
        w_out2 = r_slot2;
        if (r_slot1 == NONE || (r_slot2 != NONE && r_slot2 < r_slot1)) begin
            w_out1 = r_slot2;
            w_out2 = r_slot1;
        end
    end
`else
    assign w_out1 = r_slot1;
    assign w_out2 = r_slot2;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_next;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_slot1    <= NONE;
            r_slot2    <= NONE;
            r_dirty    <= 1'b0;
            r_vsync_d  <= 1'b1;
            r_cnt      <= 4'd0;
            r_pend     <= 1'b0;
            r_offset_q <= 1'b0;
            r_new_f_in <= 1'b0;
            r_freq_id1 <= NONE;
            r_freq_id2 <= NONE;
        end else begin
            r_slot1    <= w_slot1_next;
            r_slot2    <= w_slot2_next;
            r_vsync_d  <= i_vsync;
            r_new_f_in <= (r_state == ISSUE);
            if (i_restart || w_key_set)  r_dirty <= 1'b1;
            else if (r_state == ISSUE)   r_dirty <= 1'b0;
            if (r_state == ISSUE) begin
                r_freq_id1 <= w_out1;
                r_freq_id2 <= w_out2;
                r_cnt      <= 4'd0;
            end else if (r_state == HOLDOFF && w_fe && r_cnt != 4'hF) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // A restart arriving while the pulse is high re-arms it for one more frame.
            if (w_fe)           r_offset_q <= r_pend;
            if (i_restart)      r_pend <= 1'b1;
            else if (w_fe)      r_pend <= 1'b0;
        end
    end

    assign o_freq_id1 = r_freq_id1;
    assign o_freq_id2 = r_freq_id2;
    assign o_new_f_in = r_new_f_in;
    assign o_r_offset = r_offset_q;
    assign o_busy     = (r_state == HOLDOFF);

endmodule

// File: tb/tb_freq_scheduler.sv
// Bench for freq_scheduler: directed scenarios plus random key traffic against a held-note reference model.
module tb_freq_scheduler;

    localparam int HOLD = 4;
    localparam logic [4:0] NONE = 5'd31;

    logic       clock = 1'b0;
    logic       resetN;
    logic       vsync;
    logic       keyValid;
    logic       keyPress;
    logic [4:0] keyId;
    logic       restart;
    logic [4:0] freqId1;
    logic [4:0] freqId2;
    logic       newFIn;
    logic       rOffset;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int framePhase = 0;

    logic [4:0] heldQ[$];
    logic       mPending, mIssue, mHold, mOffPend, mVsyncPrev;
    int         mFrames;
    logic [4:0] e1, e2;
    logic       eNew, eOff, eBusy;

    freq_scheduler dut (
        .i_clock    (clock),
        .i_reset_n  (resetN),
        .i_vsync    (vsync),
        .i_key_valid(keyValid),
        .i_key_press(keyPress),
        .i_key_id   (keyId),
        .i_restart  (restart),
        .o_freq_id1 (freqId1),
        .o_freq_id2 (freqId2),
        .o_new_f_in (newFIn),
        .o_r_offset (rOffset),
        .o_busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic modelReset();
        heldQ.delete();
        mPending = 0; mIssue = 0; mHold = 0; mOffPend = 0; mVsyncPrev = 1; mFrames = 0;
        e1 = NONE; e2 = NONE; eNew = 0; eOff = 0; eBusy = 0;
    endtask

    function automatic void viewSlots(output logic [4:0] a, output logic [4:0] b);
        logic [4:0] t;
        a = (heldQ.size() > 0) ? heldQ[0] : NONE;
        b = (heldQ.size() > 1) ? heldQ[1] : NONE;
`ifdef FREQ_SCHED_SORT_EN
        if (a != NONE && b != NONE && b < a) begin
            t = a; a = b; b = t;
        end
`else
        t = a;
`endif
    endfunction

    // Held notes as an ordered list: oldest first, a third press replaces the newest.
    function automatic logic applyKey(input logic press, input logic [4:0] id);
        int idx = -1;
        foreach (heldQ[i]) if (heldQ[i] == id) idx = i;
        if (press) begin
            if (id > 5'd24 || idx >= 0) return 1'b0;
            if (heldQ.size() < 2) heldQ.push_back(id);
            else                  heldQ[1] = id;
            return 1'b1;
        end
        if (idx < 0) return 1'b0;
        heldQ.delete(idx);
        return 1'b1;
    endfunction

    task automatic modelStep();
        logic fe, changed, nIssue, nHold;
        logic [4:0] a, b;
        fe = mVsyncPrev && !vsync;
        mVsyncPrev = vsync;
        if (mIssue) begin
            viewSlots(a, b);
            e1 = a;
            e2 = b;
        end
        eNew = mIssue;
        if (fe) eOff = mOffPend;
        if (restart)  mOffPend = 1;
        else if (fe)  mOffPend = 0;
        changed = 0;
        if (restart)       heldQ.delete();
        else if (keyValid) changed = applyKey(keyPress, keyId);
        nIssue = 0;
        nHold  = mHold;
        if (restart) begin
            nIssue = 1; nHold = 0; mPending = 1;
        end else if (mIssue) begin
            nHold = 1; mFrames = 0; mPending = changed;
        end else if (mHold) begin
            if (mFrames >= HOLD) nHold = 0;
            else if (fe)         mFrames++;
            mPending = mPending | changed;
        end else begin
            nIssue   = mPending | changed;
            mPending = mPending | changed;
        end
        mIssue = nIssue;
        mHold  = nHold;
        eBusy  = nHold;
    endtask

    task automatic doCheck(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        doCheck("freq_id1", freqId1, e1);
        doCheck("freq_id2", freqId2, e2);
        doCheck("new_f_in", 5'(newFIn), 5'(eNew));
        doCheck("r_offset", 5'(rOffset), 5'(eOff));
        doCheck("busy", 5'(busy), 5'(eBusy));
    endtask

    task automatic applyStimulus(input logic kv, input logic kp, input logic [4:0] kid, input logic rs);
        keyValid = kv;
        keyPress = kp;
        keyId    = kid;
        restart  = rs;
        vsync    = (framePhase % 6) < 3;
        framePhase++;
        @(posedge clock);
        modelStep();
        #1;
        checkOutput();
        keyValid = 0;
        restart  = 0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 5'd0, 0);
    endtask

    task automatic waitSettle();
        int n = 0;
        while ((mIssue || mHold || mPending || eNew || busy) && n < 200) begin
            applyStimulus(0, 0, 5'd0, 0);
            n++;
        end
        doCheck("settle_busy", 5'(busy), 5'd0);
    endtask

    task automatic asyncReset();
        #2 resetN = 0;
        #1;
        modelReset();
        doCheck("async_id1", freqId1, NONE);
        doCheck("async_id2", freqId2, NONE);
        doCheck("async_new", 5'(newFIn), 5'd0);
        doCheck("async_off", 5'(rOffset), 5'd0);
        doCheck("async_busy", 5'(busy), 5'd0);
        @(posedge clock);
        #1 resetN = 1;
    endtask

    initial begin
        int pulses;
        resetN = 0; vsync = 1; keyValid = 0; keyPress = 0; keyId = 0; restart = 0;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        doCheck("reset_id1", freqId1, NONE);
        doCheck("reset_id2", freqId2, NONE);
        doCheck("reset_new", 5'(newFIn), 5'd0);
        doCheck("reset_off", 5'(rOffset), 5'd0);
        doCheck("reset_busy", 5'(busy), 5'd0);
        resetN = 1;

        $display("[TB] single press latency");
        applyStimulus(1, 1, 5'd7, 0);
        applyStimulus(0, 0, 5'd0, 0);
        doCheck("lat_new", 5'(newFIn), 5'd1);
        doCheck("lat_id1", freqId1, 5'd7);
        doCheck("lat_id2", freqId2, NONE);
        doCheck("lat_busy", 5'(busy), 5'd1);
        waitSettle();

        $display("[TB] coalescing within holdoff");
        applyStimulus(1, 0, 5'd7, 0);
        waitSettle();
        applyStimulus(1, 1, 5'd7, 0);
        idleCycles(3);
        applyStimulus(1, 1, 5'd12, 0);
        idleCycles(2);
        applyStimulus(1, 0, 5'd7, 0);
        waitSettle();
        doCheck("coal_id1", freqId1, 5'd12);
        doCheck("coal_id2", freqId2, NONE);

        $display("[TB] newest press overwrites slot2");
        applyStimulus(1, 0, 5'd12, 0);
        waitSettle();
        applyStimulus(1, 1, 5'd3, 0);
        idleCycles(2);
        applyStimulus(1, 1, 5'd9, 0);
        applyStimulus(1, 1, 5'd20, 0);
        while (!eNew && mFrames < 100) applyStimulus(0, 0, 5'd0, 0);
        doCheck("ovw_id1", freqId1, 5'd3);
        doCheck("ovw_id2", freqId2, 5'd20);

        $display("[TB] restart during holdoff");
        idleCycles(3);
        applyStimulus(0, 0, 5'd0, 1);
        applyStimulus(0, 0, 5'd0, 0);
        doCheck("rst_new", 5'(newFIn), 5'd1);
        doCheck("rst_id1", freqId1, NONE);
        doCheck("rst_id2", freqId2, NONE);
        waitSettle();

        $display("[TB] ignored presses");
        applyStimulus(1, 1, 5'd3, 0);
        waitSettle();
        applyStimulus(1, 1, 5'd9, 0);
        waitSettle();
        pulses = 0;
        applyStimulus(1, 1, 5'd25, 0);
        if (newFIn) pulses++;
        applyStimulus(1, 1, 5'd9, 0);
        if (newFIn) pulses++;
        applyStimulus(1, 1, 5'd9, 0);
        if (newFIn) pulses++;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 5'd0, 0);
            if (newFIn) pulses++;
        end
        doCheck("ignored_pulses", 5'(pulses), 5'd0);

        $display("[TB] key and restart together");
        applyStimulus(1, 1, 5'd8, 1);
        applyStimulus(0, 0, 5'd0, 0);
        doCheck("kr_new", 5'(newFIn), 5'd1);
        doCheck("kr_id1", freqId1, NONE);
        doCheck("kr_id2", freqId2, NONE);
        waitSettle();

        $display("[TB] async reset in holdoff");
        applyStimulus(1, 1, 5'd6, 0);
        idleCycles(4);
        asyncReset();

        $display("[TB] two-note ordering");
        applyStimulus(1, 1, 5'd15, 0);
        idleCycles(2);
        applyStimulus(1, 1, 5'd4, 0);
        waitSettle();
`ifdef FREQ_SCHED_SORT_EN
        doCheck("order_id1", freqId1, 5'd4);
        doCheck("order_id2", freqId2, 5'd15);
`else
        doCheck("order_id1", freqId1, 5'd15);
        doCheck("order_id2", freqId2, 5'd4);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 27)), $urandom_range(0, 99) < 2);
        end
        waitSettle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_scheduler.md
Name: freq_scheduler

Overview:
- Sequences frequency changes into the physics block.
- Tracks up to two held keyboard notes and converts press/release events into freq_id1/freq_id2 plus a one-cycle new_f_in pulse.
- Rate-limits changes to one per HOLDOFF_FRAMES frames so each waveform blend can progress.
- Generates the one-frame r_offset pulse on game restart.

Parameters:
- HOLDOFF_FRAMES, 4: minimum vsync falling edges between successive new_f_in pulses; legal range 1..15.
- MAX_ID, 24: highest valid frequency id; larger press ids are ignored.
- NONE_ID, 31: "no frequency" code driven on an empty channel.

Ports:
- clock, in, 1: 65 MHz pixel clock.
- reset_n, in, 1: asynchronous active-low reset.
- vsync, in, 1: frame sync in the clock domain; falling edge marks a frame.
- key_valid, in, 1: one-cycle strobe; a key event is present.
- key_press, in, 1: 1 = press, 0 = release; qualified by key_valid.
- key_id, in, 5: frequency id of the event.
- restart, in, 1: one-cycle strobe requesting a game restart.
- freq_id1, out, 5: primary frequency id to physics.
- freq_id2, out, 5: secondary frequency id to physics; NONE_ID if unused.
- new_f_in, out, 1: one-cycle pulse; freq_id1/2 are valid and new.
- r_offset, out, 1: offset reset to physics; high for exactly one frame.
- busy, out, 1: high while state is HOLDOFF.

Behaviour:
- Reset (async, reset_n low):
  - slot1 = slot2 = freq_id1 = freq_id2 = NONE_ID.
  - new_f_in = 0, r_offset = 0, busy = 0, dirty = 0.
  - State IDLE, frame counter 0, vsync history register = 1.
- Frame edge: fe = vsync_d & ~vsync, where vsync_d is vsync registered once. fe is one cycle long.
- Slot update, evaluated on each key_valid cycle:
  - Press with key_id > MAX_ID: ignored.
  - Press with key_id equal to slot1 or slot2: ignored, dirty unchanged.
  - Press, otherwise: fill slot1 if it is NONE_ID; else fill slot2 if it is NONE_ID; else overwrite slot2 (newest wins). Set dirty.
  - Release matching slot1: slot1 <= slot2, slot2 <= NONE_ID, set dirty.
  - Release matching slot2 only: slot2 <= NONE_ID, set dirty.
  - Release matching neither slot: ignored.
- State machine:
  - IDLE: if dirty, go to ISSUE next cycle.
  - ISSUE (one cycle):
    - freq_id1 <= slot1 and freq_id2 <= slot2, both registered.
    - new_f_in = 1 on the same cycle the new ids first appear.
    - dirty cleared, unless a key event occurs in this same cycle; that event re-sets dirty.
    - Frame counter <= 0; go to HOLDOFF.
  - HOLDOFF: counter increments on each fe. When counter reaches HOLDOFF_FRAMES, go to IDLE on the next cycle. Key events are still absorbed into the slots (coalesced); the outputs do not change.
- Latency: key event at cycle t with state IDLE gives new_f_in at t+2.
- The outputs are stable whenever new_f_in is 0, apart from reset and restart.
- Restart:
  - Takes priority over a key event in the same cycle; that key event is dropped.
  - Slots cleared to NONE_ID and dirty set.
  - State forced to ISSUE next cycle, aborting any HOLDOFF, which yields new_f_in with NONE_ID/NONE_ID.
  - r_pend set. At the next fe, r_offset <= 1 and r_pend cleared. At the following fe, r_offset <= 0.
  - A restart while r_offset is already high re-arms r_pend: r_offset stays high one more frame.
- Counter width: 4 bits, saturating; it never wraps.

Optional Feature:
- FREQ_SCHED_SORT_EN, defined: in ISSUE, if both slots are valid, freq_id1 gets the smaller id and freq_id2 the larger. NONE_ID always goes on freq_id2. Internal slot order is unchanged.
- Not defined: freq_id1/2 mirror slot1/slot2 as-is.

Test Plan:
- Reset, then press id 7 with HOLDOFF_FRAMES=4 -> new_f_in pulse 2 cycles later; freq_id1=7, freq_id2=31; busy high until the 4th fe.
- Press 7, press 12, release 7, all within one holdoff -> only the first pulse (7/31) during holdoff; after holdoff a single pulse with freq_id1=12, freq_id2=31.
- Press 3, 9, then 20 -> 20 overwrites slot2; final output 3/20. Press 25 and press 9 twice -> no new pulse.
- Restart mid-HOLDOFF with slots 3/20 -> next-cycle pulse 31/31; r_offset high from the next fe through the following fe; busy restarts its count.
- Key press and restart in the same cycle -> key dropped; outputs 31/31.
- Assert reset_n low mid-HOLDOFF asynchronously -> all outputs at reset values immediately, with no clock edge required. With FREQ_SCHED_SORT_EN defined, press 15 then 4 -> outputs 4/15.
